// File: rtl/kypd_pkg.sv
// Shared definitions for the Pmod KYPD guess-entry block: key codes,
// keypad position map and edit FSM encoding.
package kypd_pkg;

   localparam logic [3:0] KEY_BSP = 4'hB;
   localparam logic [3:0] KEY_CLR = 4'hC;
   localparam logic [3:0] KEY_ENT = 4'hE;

   typedef enum logic {ST_EDIT, ST_SUBMIT} state_t;

   // Physical layout: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/kypd_scan_debounce.sv
// Column scanner and full-scan debouncer for the 4x4 keypad; emits one
// strobe per press with no auto-repeat.
module kypd_scan_debounce
   import kypd_pkg::*;
#(
   parameter int DWELL          = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] kypd_col,
   input  logic [3:0] kypd_row,
   output logic [3:0] key_code,
   output logic       key_strobe
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [DW-1:0] dwell_cnt;
   logic [1:0]    col_idx;
   logic [3:0]    row_meta, row_sync;
   logic [1:0]    hit_cnt;
   logic [3:0]    hit_code;
   logic [4:0]    res_q;
   logic [CW-1:0] db_cnt, cnt_nxt;
   logic          armed;

   logic       last_dwell, scan_done, scan_key;
   logic [2:0] col_hits, tot_hits;
   logic [3:0] col_code, tot_code;
   logic [4:0] scan_res;

   assign kypd_col   = ~(4'b0001 << col_idx);
   assign last_dwell = (dwell_cnt == DW'(DWELL - 1));
   assign scan_done  = last_dwell && (col_idx == 2'd3);

   always_comb begin
      col_hits = 3'd0;
      col_code = 4'h0;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync[r]) begin
            col_hits = col_hits + 3'd1;
            col_code = key_map(2'(r), col_idx);
         end
      end
   end

   // Scan result includes the column being sampled right now; two or more hits is MULTI -> NONE.
   assign tot_hits = {1'b0, hit_cnt} + col_hits;
   assign tot_code = (col_hits != 3'd0) ? col_code : hit_code;
   assign scan_key = (tot_hits == 3'd1);
   assign scan_res = {scan_key, scan_key ? tot_code : 4'h0};

   always_comb begin
      if (scan_res != res_q)                     cnt_nxt = CW'(1);
      else if (db_cnt == CW'(DEBOUNCE_SCANS))    cnt_nxt = db_cnt;
      else                                       cnt_nxt = db_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_cnt  <= '0;
         col_idx    <= 2'd0;
         row_meta   <= 4'hF;
         row_sync   <= 4'hF;
         hit_cnt    <= 2'd0;
         hit_code   <= 4'h0;
         res_q      <= 5'd0;
         db_cnt     <= '0;
         armed      <= 1'b0;
         key_code   <= 4'h0;
         key_strobe <= 1'b0;
      end else begin
         row_meta   <= kypd_row;
         row_sync   <= row_meta;
         key_strobe <= 1'b0;
         if (last_dwell) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
            hit_code  <= tot_code;
            hit_cnt   <= scan_done ? 2'd0 : ((tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0]);
         end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
         end
         if (scan_done) begin
            res_q  <= scan_res;
            db_cnt <= cnt_nxt;
            if (cnt_nxt == CW'(DEBOUNCE_SCANS)) begin
               if (scan_key && !armed) begin
                  key_strobe <= 1'b1;
                  key_code   <= tot_code;
                  armed      <= 1'b1;
               end else if (!scan_key) begin
                  armed <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/kypd_guess_entry.sv
// Numberle guess entry: keypad scan/debounce feeding an edit buffer that
// offers completed guesses downstream over valid/ready.
module kypd_guess_entry
   import kypd_pkg::*;
#(
   parameter int NUM_DIGITS          = 4,
   parameter int CLK_HZ              = 100_000_000,
   parameter int SCAN_US             = 1000,
   parameter int DEBOUNCE_SCANS      = 4,
   parameter int ALLOW_REPEAT_DIGITS = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic [3:0]                        kypd_col,
   input  logic [3:0]                        kypd_row,
   input  logic                              en,
   output logic [3:0]                        key_code,
   output logic                              key_strobe,
   output logic                              reject,
   output logic [4*NUM_DIGITS-1:0]           guess_data,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   guess_len,
   output logic                              guess_valid,
   input  logic                              guess_ready
);

   localparam int LW    = $clog2(NUM_DIGITS + 1);
   localparam int DWELL = CLK_HZ / 1_000_000 * SCAN_US;

   state_t                  state, state_nxt;
   logic [4*NUM_DIGITS-1:0] data_nxt;
   logic [LW-1:0]           len_nxt;
   logic                    rej_nxt, dup, hs, key_ev;

   kypd_scan_debounce #(.DWELL(DWELL), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_scan (
      .clk        (clk),
      .rst        (rst),
      .kypd_col   (kypd_col),
      .kypd_row   (kypd_row),
      .key_code   (key_code),
      .key_strobe (key_strobe)
   );

   assign hs     = guess_valid && guess_ready;
   assign key_ev = key_strobe && en;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_EDIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EDIT:   if (key_ev && key_code == KEY_ENT && guess_len == LW'(NUM_DIGITS))
                       state_nxt = ST_SUBMIT;
         ST_SUBMIT: if (hs) state_nxt = ST_EDIT;
         default:   state_nxt = ST_EDIT;
      endcase
   end

   always_comb begin
      guess_valid = (state == ST_SUBMIT);
   end

   // Only occupied slots count for the duplicate check, since 0 is a legal digit.
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (LW'(i) < guess_len && guess_data[4*(NUM_DIGITS-1-i) +: 4] == key_code)
            dup = 1'b1;
   end

   always_comb begin
      data_nxt = guess_data;
      len_nxt  = guess_len;
      rej_nxt  = 1'b0;
      if (hs) begin
         data_nxt = '0;
         len_nxt  = '0;
         rej_nxt  = key_ev;
      end else if (key_ev) begin
         if (state == ST_SUBMIT) begin
            rej_nxt = 1'b1;
         end else if (key_code <= 4'd9) begin
            if (guess_len < LW'(NUM_DIGITS) && (ALLOW_REPEAT_DIGITS != 0 || !dup)) begin
               for (int i = 0; i < NUM_DIGITS; i++)
                  if (LW'(i) == guess_len) data_nxt[4*(NUM_DIGITS-1-i) +: 4] = key_code;
               len_nxt = guess_len + LW'(1);
            end else begin
               rej_nxt = 1'b1;
            end
         end else begin
            case (key_code)
               KEY_BSP: begin
                  if (guess_len != '0) begin
                     for (int i = 0; i < NUM_DIGITS; i++)
                        if (LW'(i) == guess_len - LW'(1)) data_nxt[4*(NUM_DIGITS-1-i) +: 4] = 4'h0;
                     len_nxt = guess_len - LW'(1);
                  end else begin
                     rej_nxt = 1'b1;
                  end
               end
               KEY_CLR: begin
                  data_nxt = '0;
                  len_nxt  = '0;
               end
               KEY_ENT: rej_nxt = (guess_len != LW'(NUM_DIGITS));
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         guess_data <= '0;
         guess_len  <= '0;
         reject     <= 1'b0;
      end else begin
         guess_data <= data_nxt;
         guess_len  <= len_nxt;
         reject     <= rej_nxt;
      end
   end

endmodule

// File: tb/tb_kypd_guess_entry.sv
// Directed bench for kypd_guess_entry: a keypad matrix model drives the rows
// from the scanned columns; one instance allows repeats, one forbids them.
module tb_kypd_guess_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] keys_down = '0;
   logic        en_a = 1'b0, en_b = 1'b0, rdy_a = 1'b0, rdy_b = 1'b1;

   logic [3:0]  col_a, row_a, code_a, col_b, row_b, code_b;
   logic        strb_a, rej_a, val_a, strb_b, rej_b, val_b;
   logic [15:0] data_a, data_b;
   logic [2:0]  len_a, len_b;

   int n_tests = 0, n_fail = 0;
   int strobes_a = 0, rejects_a = 0, rejects_b = 0;
   logic [3:0] last_code_a = 4'h0;

   logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                               '{4'h4, 4'h5, 4'h6, 4'hB},
                               '{4'h7, 4'h8, 4'h9, 4'hC},
                               '{4'h0, 4'hF, 4'hE, 4'hD}};

   typedef struct {
      logic [3:0]  key;
      logic [15:0] data;
      logic [2:0]  len;
      logic        rej;
   } vec_t;
   vec_t tbl [9];

   always #5 clk = ~clk;

   kypd_guess_entry #(.NUM_DIGITS(4), .CLK_HZ(1_000_000), .SCAN_US(4), .DEBOUNCE_SCANS(2),
                      .ALLOW_REPEAT_DIGITS(1)) dut (
      .clk(clk), .rst(rst), .kypd_col(col_a), .kypd_row(row_a), .en(en_a),
      .key_code(code_a), .key_strobe(strb_a), .reject(rej_a), .guess_data(data_a),
      .guess_len(len_a), .guess_valid(val_a), .guess_ready(rdy_a));

   kypd_guess_entry #(.NUM_DIGITS(4), .CLK_HZ(1_000_000), .SCAN_US(4), .DEBOUNCE_SCANS(2),
                      .ALLOW_REPEAT_DIGITS(0)) dut_nr (
      .clk(clk), .rst(rst), .kypd_col(col_b), .kypd_row(row_b), .en(en_b),
      .key_code(code_b), .key_strobe(strb_b), .reject(rej_b), .guess_data(data_b),
      .guess_len(len_b), .guess_valid(val_b), .guess_ready(rdy_b));

   // Matrix model: a row reads low while a pressed key sits on the driven column.
   always_comb begin
      row_a = 4'hF;
      row_b = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (keys_down[r*4+c] && !col_a[c]) row_a[r] = 1'b0;
            if (keys_down[r*4+c] && !col_b[c]) row_b[r] = 1'b0;
         end
   end

   always @(negedge clk) begin
      if (strb_a) begin
         strobes_a   <= strobes_a + 1;
         last_code_a <= code_a;
      end
      if (rej_a) rejects_a <= rejects_a + 1;
      if (rej_b) rejects_b <= rejects_b + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] key_bit(input logic [3:0] k);
      logic [15:0] m;
      m = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (kmap[r][c] == k) m[r*4+c] = 1'b1;
      return m;
   endfunction

   // Hold a key until its strobe (bounded), then release long enough to disarm.
   task automatic press(input logic [3:0] k);
      int s0;
      s0 = strobes_a;
      keys_down = key_bit(k);
      for (int t = 0; t < 120 && strobes_a == s0; t++) @(negedge clk);
      chk("press_strobe", 32'(strobes_a - s0), 32'd1);
      chk("press_code", {28'd0, last_code_a}, {28'd0, k});
      keys_down = '0;
      repeat (64) @(negedge clk);
   endtask

   initial begin
      int s0, ra0, rb0;
      tbl[0] = '{4'h1, 16'h1000, 3'd1, 1'b0};
      tbl[1] = '{4'h2, 16'h1200, 3'd2, 1'b0};
      tbl[2] = '{4'h3, 16'h1230, 3'd3, 1'b0};
      tbl[3] = '{4'h4, 16'h1234, 3'd4, 1'b0};
      tbl[4] = '{4'h7, 16'h1234, 3'd4, 1'b1};
      tbl[5] = '{4'hB, 16'h1230, 3'd3, 1'b0};
      tbl[6] = '{4'hC, 16'h0000, 3'd0, 1'b0};
      tbl[7] = '{4'hA, 16'h0000, 3'd0, 1'b0};
      tbl[8] = '{4'hB, 16'h0000, 3'd0, 1'b1};

      en_a = 1'b1;
      keys_down = key_bit(4'h5);
      repeat (3) @(negedge clk);
      chk("rst_col", {28'd0, col_a}, 32'hE);
      chk("rst_len", {29'd0, len_a}, 32'd0);
      chk("rst_data", {16'd0, data_a}, 32'd0);
      chk("rst_valid", {31'd0, val_a}, 32'd0);
      chk("rst_code", {28'd0, code_a}, 32'd0);
      rst = 1'b0;

      // Key 5 held from reset release: strobe after the second full scan only.
      repeat (24) @(negedge clk);
      chk("k5_no_early_strobe", 32'(strobes_a), 32'd0);
      repeat (16) @(negedge clk);
      chk("k5_strobe_scan2", 32'(strobes_a), 32'd1);
      chk("k5_code", {28'd0, last_code_a}, 32'h5);
      repeat (60) @(negedge clk);
      chk("k5_no_repeat", 32'(strobes_a), 32'd1);
      chk("k5_data", {16'd0, data_a}, 32'h5000);
      chk("k5_len", {29'd0, len_a}, 32'd1);
      keys_down = '0;
      repeat (64) @(negedge clk);
      press(4'hC);
      chk("clr_len", {29'd0, len_a}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         ra0 = rejects_a;
         press(tbl[i].key);
         chk($sformatf("tbl%0d_data", i), {16'd0, data_a}, {16'd0, tbl[i].data});
         chk($sformatf("tbl%0d_len", i), {29'd0, len_a}, {29'd0, tbl[i].len});
         chk($sformatf("tbl%0d_rej", i), 32'(rejects_a - ra0), {31'd0, tbl[i].rej});
      end

      // No-repeat instance edits; the main instance is disabled and must stay silent.
      en_a = 1'b0; en_b = 1'b1;
      ra0 = rejects_a; rb0 = rejects_b;
      press(4'h3);
      press(4'h3);
      chk("nr_dup_rej", 32'(rejects_b - rb0), 32'd1);
      chk("nr_len", {29'd0, len_b}, 32'd1);
      chk("nr_data", {16'd0, data_b}, 32'h3000);
      press(4'hE);
      chk("nr_short_enter_rej", 32'(rejects_b - rb0), 32'd2);
      chk("nr_valid", {31'd0, val_b}, 32'd0);
      chk("en0_len", {29'd0, len_a}, 32'd0);
      chk("en0_no_rej", 32'(rejects_a - ra0), 32'd0);
      en_a = 1'b1; en_b = 1'b0;

      press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hE);
      chk("sub_valid", {31'd0, val_a}, 32'd1);
      repeat (20) @(negedge clk);
      chk("sub_hold_valid", {31'd0, val_a}, 32'd1);
      chk("sub_frozen", {16'd0, data_a}, 32'h9876);
      ra0 = rejects_a;
      press(4'h1);
      chk("sub_key_rej", 32'(rejects_a - ra0), 32'd1);
      chk("sub_key_data", {16'd0, data_a}, 32'h9876);
      chk("sub_key_len", {29'd0, len_a}, 32'd4);
      rdy_a = 1'b1;
      @(negedge clk);
      rdy_a = 1'b0;
      chk("hs_valid", {31'd0, val_a}, 32'd0);
      chk("hs_len", {29'd0, len_a}, 32'd0);
      chk("hs_data", {16'd0, data_a}, 32'd0);

      s0 = strobes_a;
      keys_down = key_bit(4'h5) | key_bit(4'h6);
      repeat (100) @(negedge clk);
      chk("multi_no_strobe", 32'(strobes_a - s0), 32'd0);
      keys_down = '0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         keys_down = (i % 2 == 0) ? key_bit(4'h5) : 16'h0;
         repeat (16) @(negedge clk);
      end
      keys_down = '0;
      repeat (64) @(negedge clk);
      chk("bounce_no_strobe", 32'(strobes_a - s0), 32'd0);
      chk("bounce_len", {29'd0, len_a}, 32'd0);

      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
      chk("sub2_valid", {31'd0, val_a}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_sub_valid", {31'd0, val_a}, 32'd0);
      chk("rst_sub_col", {28'd0, col_a}, 32'hE);
      chk("rst_sub_len", {29'd0, len_a}, 32'd0);
      chk("rst_sub_data", {16'd0, data_a}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
